// File: rtl/multicycle_controller_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and mux/ALU encodings shared by the multicycle controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;
  localparam logic [1:0] SRC_B_RS2 = 2'b00;
  localparam logic [1:0] SRC_B_4   = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef struct packed {
    logic r;
    logic ialu;
    logic load;
    logic store;
    logic branch;
    logic jal;
  } op_class_t;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: datapath and unified-memory signals seen by the controller
interface multicycle_controller_if #(parameter int ALUOP_W = 2);
  logic [6:0] opcode;
  logic zero, mem_ready;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic instr_done, illegal_instr, bus_error;
  logic [1:0] alu_src_a, alu_src_b, mem_to_reg;
  logic [ALUOP_W-1:0] alu_op;
  modport master(
    input opcode, zero, mem_ready,
    output pc_write, ir_write, i_or_d, alu_src_a, alu_src_b, alu_op, mem_read, mem_write,
    output reg_write, mem_to_reg, instr_done, illegal_instr, bus_error
  );
  modport slave(
    output opcode, zero, mem_ready,
    input pc_write, ir_write, i_or_d, alu_src_a, alu_src_b, alu_op, mem_read, mem_write,
    input reg_write, mem_to_reg, instr_done, illegal_instr, bus_error
  );
endinterface

// File: rtl/multicycle_controller_opcode_class_decoder.sv
// opcode_class_decoder: maps an RV32I opcode to a one-hot instruction class (all zero = illegal)
module opcode_class_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter bit EN_JAL = 1'b1
) (
  input  logic [6:0] opcode_i,
  output op_class_t  cls_o
);
  assign cls_o = '{
    r:      opcode_i == OP_R,
    ialu:   opcode_i == OP_IALU,
    load:   opcode_i == OP_LOAD,
    store:  opcode_i == OP_STORE,
    branch: opcode_i == OP_BRANCH,
    jal:    EN_JAL && opcode_i == OP_JAL
  };
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences RV32I instructions through FETCH/DECODE/EXEC/MEM/WB with memory timeout and traps
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int TIMEOUT = 16,
  parameter bit EN_JAL  = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state_q, state_d;
  logic [6:0] opc_q;
  logic [CW-1:0] wait_q, wait_d;
  logic illegal_q, bus_err_q;
  op_class_t cls_in, cls_q;
  logic legal_in, waiting, timeout;
  logic fe, de, ex, me, wb;
  opcode_class_decoder #(.EN_JAL(EN_JAL)) u_dec_in (.opcode_i(bus.opcode), .cls_o(cls_in));
  opcode_class_decoder #(.EN_JAL(EN_JAL)) u_dec_q  (.opcode_i(opc_q), .cls_o(cls_q));
  assign legal_in = cls_in != '0;
  assign {fe, de, ex, me, wb} = {state_q == FETCH, state_q == DECODE, state_q == EXEC, state_q == MEM, state_q == WB};
  assign waiting = (fe | me) & ~bus.mem_ready;
  assign timeout = waiting && wait_q == CW'(TIMEOUT - 1);
  // state register, wait counter and sticky trap flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      opc_q     <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      if (de) opc_q <= bus.opcode;
      illegal_q <= illegal_q | (de & ~legal_in);
      bus_err_q <= bus_err_q | timeout;
    end
  end
  // next state; a ready memory on the last allowed cycle beats the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = bus.mem_ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE:  state_d = legal_in ? EXEC : TRAP;
      EXEC:    state_d = cls_q.branch ? FETCH : (cls_q.load | cls_q.store) ? MEM : WB;
      MEM:     state_d = bus.mem_ready ? (cls_q.load ? WB : FETCH) : timeout ? TRAP : MEM;
      WB:      state_d = FETCH;
      default: state_d = TRAP;
    endcase
    wait_d = state_d != state_q ? '0 : waiting ? wait_q + 1'b1 : wait_q;
  end
  // control outputs from the current state and latched opcode class
  always_comb begin
    bus.mem_read      = fe | (me & cls_q.load);
    bus.mem_write     = me & cls_q.store;
    bus.i_or_d        = me;
    bus.ir_write      = fe & bus.mem_ready;
    bus.pc_write      = (fe & bus.mem_ready) | (ex & ((cls_q.branch & bus.zero) | cls_q.jal));
    bus.alu_src_a     = de ? SRC_A_OLDPC : (ex & ~cls_q.jal) ? SRC_A_RS1 : SRC_A_PC;
    bus.alu_src_b     = fe ? SRC_B_4 : (de | (ex & (cls_q.ialu | cls_q.load | cls_q.store))) ? SRC_B_IMM : SRC_B_RS2;
    bus.alu_op        = ALUOP_W'((ex & (cls_q.r | cls_q.ialu)) ? ALU_FUNCT : (ex & cls_q.branch) ? ALU_BRANCH : ALU_ADD);
    bus.reg_write     = wb;
    bus.mem_to_reg    = ~wb ? WB_ALU : cls_q.load ? WB_MDR : cls_q.jal ? WB_PC4 : WB_ALU;
    bus.instr_done    = wb | (ex & cls_q.branch) | (me & cls_q.store & bus.mem_ready);
    bus.illegal_instr = illegal_q;
    bus.bus_error     = bus_err_q;
  end
endmodule
